conv_unit_mc: RTL and testbench

//  Parametrised multi-channel FxF float16 convolution unit; successor to the fixed 3-channel/3x3 conv unit.

---
 rtl/conv_unit_mc_if.sv | 22 ++
 rtl/conv_unit_mc.sv | 188 ++++++++++++++++++
 tb/tb_conv_unit_mc.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/conv_unit_mc_if.sv
// Pixel stream, kernel/bias configuration and result bundle for conv_unit_mc.
// The unit uses the slave view; the feature-map streamer uses the master view.
interface conv_unit_mc_if #(
    parameter int DATA_WIDTH = 16,
    parameter int D          = 3,
    parameter int F          = 3
);
    logic                        iSof;
    logic                        iValid;
    logic [DATA_WIDTH*D-1:0]     iData;
    logic [DATA_WIDTH*F*F*D-1:0] param;
    logic [DATA_WIDTH-1:0]       bias;
    logic                        relu_en;
    logic                        oValid;
    logic                        oLast;
    logic [DATA_WIDTH-1:0]       result;

    modport master (output iSof, iValid, iData, param, bias, relu_en,
                    input  oValid, oLast, result);
    modport slave  (input  iSof, iValid, iData, param, bias, relu_en,
                    output oValid, oLast, result);
endinterface

// File: rtl/conv_unit_mc.sv
// Multi-channel FxF float16 convolution: raster pixel in, one result per strided window out.
// Six register stages: window/param capture, products, channel trees, channel sum, bias, ReLU.
module conv_unit_mc #(
    parameter int DATA_WIDTH = 16,
    parameter int D          = 3,
    parameter int F          = 3,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int STRIDE     = 1,
    parameter int LAT        = 6
) (
    input logic           clk,
    input logic           rst_n,
    conv_unit_mc_if.slave bus
);
    localparam int DW       = DATA_WIDTH;
    localparam int K        = F * F;
    localparam int OUT_W    = (IMG_W - F) / STRIDE + 1;
    localparam int OUT_H    = (IMG_H - F) / STRIDE + 1;
    localparam int LAST_ROW = F - 1 + (OUT_H - 1) * STRIDE;
    localparam int LAST_COL = F - 1 + (OUT_W - 1) * STRIDE;
    localparam int SR_LEN   = (F - 1) * IMG_W + F;
    localparam int TREE_MAX = (K > D) ? K : D;
    localparam int RW       = $clog2(IMG_H);
    localparam int CW       = $clog2(IMG_W);

    // Round-to-nearest-even pack; subnormal results flush to signed zero.
    function automatic logic [15:0] f16_pack(input logic s, input int e, input logic [9:0] m,
                                             input logic g, input logic st);
        logic [10:0] mr;
        int          er;
        mr = {1'b0, m} + 11'(g && (st || m[0]));
        er = e + int'(mr[10]);
        if (er >= 31) return {s, 5'h1f, 10'h0};
        if (er <= 0)  return {s, 15'h0};
        return {s, er[4:0], mr[9:0]};
    endfunction

    function automatic logic [15:0] f16_mul(input logic [15:0] a, input logic [15:0] b);
        logic        s;
        logic [21:0] p;
        int          e;
        s = a[15] ^ b[15];
        if (a[14:10] == 5'h1f || b[14:10] == 5'h1f) return {s, 5'h1f, 10'h0};
        if (a[14:10] == 5'h00 || b[14:10] == 5'h00) return {s, 15'h0};
        p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
        e = int'(a[14:10]) + int'(b[14:10]) - 15;
        if (p[21]) return f16_pack(s, e + 1, p[20:11], p[10], |p[9:0]);
        return f16_pack(s, e, p[19:10], p[9], |p[8:0]);
    endfunction

    function automatic logic [15:0] f16_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x, y;
        logic [23:0] mx, my, mask;
        logic [24:0] s;
        logic        sticky;
        int          d, p, e;
        if (a[14:10] == 5'h00) return (b[14:10] == 5'h00) ? 16'h0000 : b;
        if (b[14:10] == 5'h00) return a;
        if (a[14:10] == 5'h1f) return a;
        if (b[14:10] == 5'h1f) return b;
        if (a[14:0] >= b[14:0]) begin x = a; y = b; end
        else                    begin x = b; y = a; end
        d      = int'(x[14:10]) - int'(y[14:10]);
        mx     = {1'b1, x[9:0], 13'h0};
        my     = {1'b1, y[9:0], 13'h0};
        sticky = 1'b0;
        if (d > 23) begin
            my = 24'd1;
        end else begin
            mask   = (24'd1 << d) - 24'd1;
            sticky = |(my & mask);
            my     = (my >> d) | {23'h0, sticky};
        end
        s = (x[15] == y[15]) ? ({1'b0, mx} + {1'b0, my}) : ({1'b0, mx} - {1'b0, my});
        if (s == '0) return 16'h0000;
        p = 0;
        for (int i = 0; i < 25; i++) if (s[i]) p = i;
        e = int'(x[14:10]) + p - 23;
        if (p == 24) s = (s >> 1) | {24'h0, s[0]};
        else         s = s << (23 - p);
        return f16_pack(x[15], e, s[22:13], s[12], |s[11:0]);
    endfunction

    // Pairwise reduction of the first n entries; an odd leftover passes up a level unchanged.
    function automatic logic [15:0] tree_sum(input logic [15:0] v [TREE_MAX], input int n);
        logic [15:0] t [TREE_MAX];
        int          len;
        t   = v;
        len = n;
        for (int lvl = 0; lvl <= $clog2(TREE_MAX); lvl++) begin
            if (len > 1) begin
                for (int i = 0; i < TREE_MAX / 2; i++)
                    if (i < len / 2) t[i] = f16_add(t[2*i], t[2*i+1]);
                if (len % 2 == 1) t[len/2] = t[len-1];
                len = (len + 1) / 2;
            end
        end
        return t[0];
    endfunction

    logic [RW-1:0]       row_q, row_d, cur_row;
    logic [CW-1:0]       col_q, col_d, cur_col;
    logic                win_vld, win_last;
    logic [LAT-1:0]      vld_q, lst_q;
    logic [DW-1:0]       result_q;
    logic [D*DW-1:0]     sr_q [SR_LEN];
    logic [DW*K*D-1:0]   par_q;
    logic [DW-1:0]       bias_q [4];
    logic                relu_q [5];
    logic [DW-1:0]       prod_q [D][K];
    logic [DW-1:0]       chsum_d [D];
    logic [DW-1:0]       chsum_q [D];
    logic [DW-1:0]       tot_q, pre_q;

    always_comb begin
        cur_row  = bus.iSof ? '0 : row_q;
        cur_col  = bus.iSof ? '0 : col_q;
        row_d    = row_q;
        col_d    = col_q;
        win_vld  = 1'b0;
        win_last = 1'b0;
        if (bus.iValid) begin
            if (cur_col == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end
            win_vld  = (int'(cur_row) >= F - 1) && (int'(cur_col) >= F - 1) &&
                       ((int'(cur_row) - (F - 1)) % STRIDE == 0) &&
                       ((int'(cur_col) - (F - 1)) % STRIDE == 0);
            win_last = win_vld && (int'(cur_row) == LAST_ROW) && (int'(cur_col) == LAST_COL);
        end
    end

    always_comb begin
        logic [15:0] tv [TREE_MAX];
        for (int c = 0; c < D; c++) begin
            for (int i = 0; i < TREE_MAX; i++) tv[i] = 16'h0000;
            for (int k = 0; k < K; k++) tv[k] = prod_q[c][k];
            chsum_d[c] = tree_sum(tv, K);
        end
    end

    // Line buffer: a single shift chain whose taps at (F-1-r)*IMG_W + (F-1-c) form the window.
    always_ff @(posedge clk) begin
        logic [15:0] cv [TREE_MAX];
        if (bus.iValid) begin
            sr_q[0]   <= bus.iData;
            for (int i = 1; i < SR_LEN; i++) sr_q[i] <= sr_q[i-1];
            par_q     <= bus.param;
            bias_q[0] <= bus.bias;
            relu_q[0] <= bus.relu_en;
        end
        for (int i = 1; i < 4; i++) bias_q[i] <= bias_q[i-1];
        for (int i = 1; i < 5; i++) relu_q[i] <= relu_q[i-1];
        for (int c = 0; c < D; c++)
            for (int k = 0; k < K; k++)
                prod_q[c][k] <= f16_mul(sr_q[(F-1-k/F)*IMG_W + (F-1-k%F)][c*DW +: DW],
                                        par_q[(c*K + k)*DW +: DW]);
        chsum_q <= chsum_d;
        for (int i = 0; i < TREE_MAX; i++) cv[i] = (i < D) ? chsum_q[i % D] : 16'h0000;
        tot_q   <= tree_sum(cv, D);
        pre_q   <= f16_add(tot_q, bias_q[3]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q    <= '0;
            col_q    <= '0;
            vld_q    <= '0;
            lst_q    <= '0;
            result_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            vld_q <= {vld_q[LAT-2:0], win_vld};
            lst_q <= {lst_q[LAT-2:0], win_last};
            if (vld_q[LAT-2]) result_q <= (relu_q[4] && pre_q[15]) ? '0 : pre_q;
        end
    end

    assign bus.oValid = vld_q[LAT-1];
    assign bus.oLast  = lst_q[LAT-1];
    assign bus.result = result_q;
endmodule

// File: tb/tb_conv_unit_mc.sv
// Directed bench: 4x4 stride-1 and 5x5 stride-2 instances, pulse timing/value/last checks.
module tb_conv_unit_mc;
    localparam int LAT = 6;
    localparam logic [47:0] ONES = {3{16'h3C00}};
    localparam logic [47:0] CH1_TWO = 48'h0000_4000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_unit_mc_if #(.DATA_WIDTH(16), .D(3), .F(3)) bus_a ();
    conv_unit_mc_if #(.DATA_WIDTH(16), .D(3), .F(3)) bus_b ();

    conv_unit_mc #(.DATA_WIDTH(16), .D(3), .F(3), .IMG_W(4), .IMG_H(4), .STRIDE(1), .LAT(LAT))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    conv_unit_mc #(.DATA_WIDTH(16), .D(3), .F(3), .IMG_W(5), .IMG_H(5), .STRIDE(2), .LAT(LAT))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    int          n_chk = 0;
    int          n_err = 0;
    int          got_cyc [$];
    logic [15:0] got_res [$];
    logic        got_last [$];
    int          exp_cyc [$];

    always @(negedge clk) begin
        if (bus_a.oValid) begin
            got_cyc.push_back(cyc); got_res.push_back(bus_a.result); got_last.push_back(bus_a.oLast);
        end
        if (bus_b.oValid) begin
            got_cyc.push_back(cyc); got_res.push_back(bus_b.result); got_last.push_back(bus_b.oLast);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input bit use_b, input logic v, input logic sof, input logic [47:0] d);
        @(posedge clk); #1;
        bus_a.iValid = use_b ? 1'b0 : v;
        bus_a.iSof   = use_b ? 1'b0 : sof;
        bus_a.iData  = d;
        bus_b.iValid = use_b ? v : 1'b0;
        bus_b.iSof   = use_b ? sof : 1'b0;
        bus_b.iData  = d;
    endtask

    // Completing pixels: 4x4/s1 -> 10,11,14,15; 5x5/s2 -> 12,14,22,24.
    task automatic frame(input bit use_b, input int gap, input logic [47:0] d);
        int npix;
        npix = use_b ? 25 : 16;
        for (int p = 0; p < npix; p++) begin
            step(use_b, 1'b1, p == 0, d);
            if (!use_b && (p == 10 || p == 11 || p == 14 || p == 15)) exp_cyc.push_back(cyc + LAT);
            if (use_b && (p == 12 || p == 14 || p == 22 || p == 24)) exp_cyc.push_back(cyc + LAT);
            for (int g = 0; g < gap; g++) step(use_b, 1'b0, 1'b0, d);
        end
        step(use_b, 1'b0, 1'b0, d);
    endtask

    task automatic verify(input string tag, input logic [15:0] exp_res, input int n_exp);
        repeat (LAT + 4) @(posedge clk);
        chk({tag, " count"}, got_cyc.size(), n_exp);
        for (int i = 0; i < n_exp; i++) begin
            if (i < got_cyc.size() && i < exp_cyc.size()) begin
                chk($sformatf("%s cyc%0d", tag, i), got_cyc[i], exp_cyc[i]);
                chk($sformatf("%s res%0d", tag, i), got_res[i], exp_res);
                chk($sformatf("%s last%0d", tag, i), got_last[i], (i == n_exp - 1) ? 1 : 0);
            end
        end
        got_cyc.delete(); got_res.delete(); got_last.delete(); exp_cyc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        bus_a.iValid = 0; bus_a.iSof = 0; bus_a.iData = '0;
        bus_a.param = {27{16'h3C00}}; bus_a.bias = 16'h0000; bus_a.relu_en = 0;
        bus_b.iValid = 0; bus_b.iSof = 0; bus_b.iData = '0;
        bus_b.param = {27{16'h3C00}}; bus_b.bias = 16'h0000; bus_b.relu_en = 0;

        @(negedge clk);
        chk("rst a oValid", bus_a.oValid, 0);
        chk("rst a oLast", bus_a.oLast, 0);
        chk("rst a result", bus_a.result, 0);
        chk("rst b oValid", bus_b.oValid, 0);
        chk("rst b oLast", bus_b.oLast, 0);
        chk("rst b result", bus_b.result, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        frame(0, 0, ONES);
        verify("T1", 16'h4EC0, 4);

        frame(0, 1, ONES);
        verify("T2", 16'h4EC0, 4);

        bus_a.bias = 16'hCF00;
        frame(0, 0, ONES);
        verify("T3 relu0", 16'hBC00, 4);
        bus_a.relu_en = 1'b1;
        frame(0, 0, ONES);
        verify("T3 relu1", 16'h0000, 4);
        bus_a.bias = 16'h0000;
        bus_a.relu_en = 1'b0;

        frame(1, 0, CH1_TWO);
        verify("T4", 16'h4C80, 4);

        for (int p = 0; p < 7; p++) step(0, 1'b1, p == 0, ONES);
        frame(0, 0, ONES);
        verify("T5", 16'h4EC0, 4);

        for (int p = 0; p < 12; p++) step(0, 1'b1, p == 0, ONES);
        step(0, 1'b0, 1'b0, ONES);
        rst_n = 1'b0;
        #2;
        chk("T6 rst oValid", bus_a.oValid, 0);
        chk("T6 rst oLast", bus_a.oLast, 0);
        chk("T6 rst result", bus_a.result, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (LAT + 4) @(posedge clk);
        chk("T6 stale pulses", got_cyc.size(), 0);
        got_cyc.delete(); got_res.delete(); got_last.delete(); exp_cyc.delete();
        frame(0, 0, ONES);
        verify("T6 after", 16'h4EC0, 4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
